// File: rtl/xrx_pkg.sv
// Shared types, limits and frame/parity helpers for the xrx receive controller.
// Build option XRX_PARITY_EN (see xrx_ctl) adds a parity bit to the frame.
package xrx_pkg;

    localparam int DATA_MIN = 5;
    localparam int DATA_MAX = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        HUNT   = 3'd5
    } xrx_state_e;

    function automatic logic [3:0] clamp_bits(input logic [3:0] n);
        logic [3:0] r;
        if (n < 4'(DATA_MIN)) begin
            r = 4'(DATA_MIN);
        end else if (n > 4'(DATA_MAX)) begin
            r = 4'(DATA_MAX);
        end else begin
            r = n;
        end
        return r;
    endfunction

    // Start + data + stop, plus one when a parity bit is carried.
    function automatic logic [5:0] frame_bits(input logic [3:0] n, input logic par);
        return 6'd2 + {2'b00, n} + {5'b00000, par};
    endfunction

    function automatic logic even_parity(input logic [DATA_MAX-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/xrx_if.sv
// Bus-side receive port of xrx_ctl: byte holding register handshake and error pulses.
// parity_err_o exists only when XRX_PARITY_EN is defined.
interface xrx_if;
    import xrx_pkg::*;

    logic [DATA_MAX-1:0] dat_o;
    logic                stb_o;
    logic                ack_i;
    logic                frame_err_o;
    logic                overrun_o;
`ifdef XRX_PARITY_EN
    logic                parity_err_o;
`endif

    modport master (
        input  ack_i,
        output dat_o, stb_o, frame_err_o, overrun_o
`ifdef XRX_PARITY_EN
        , parity_err_o
`endif
    );

    modport slave (
        output ack_i,
        input  dat_o, stb_o, frame_err_o, overrun_o
`ifdef XRX_PARITY_EN
        , parity_err_o
`endif
    );

endinterface

// File: rtl/xrx_hold.sv
// Received-byte holding register with stb/ack handshake; a byte arriving while
// the previous one is still unacknowledged is dropped and flagged as overrun.
module xrx_hold
    import xrx_pkg::*;
(
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                load_i,
    input  logic [DATA_MAX-1:0] byte_i,
    input  logic                ack_i,
    output logic [DATA_MAX-1:0] dat_o,
    output logic                stb_o,
    output logic                overrun_o
);

    logic [DATA_MAX-1:0] dat_r;
    logic                stb_r;
    logic                overrun_r;

    // Holding register update; an ack in the completion cycle frees the slot for the new byte.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            dat_r     <= {DATA_MAX{1'b0}};
            stb_r     <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= 1'b0;
            if (load_i) begin
                if (stb_r && !ack_i) begin
                    overrun_r <= 1'b1;
                end else begin
                    dat_r <= byte_i;
                    stb_r <= 1'b1;
                end
            end else if (ack_i) begin
                stb_r <= 1'b0;
            end else begin
                stb_r <= stb_r;
            end
        end
    end

    assign dat_o     = dat_r;
    assign stb_o     = stb_r;
    assign overrun_o = overrun_r;

endmodule

// File: rtl/xrx_ctl.sv
// Receive-frame controller sequencing the xsr bit-timing engine: latches frame config,
// checks start/stop, assembles LSB-first data. Define XRX_PARITY_EN for a parity bit.
module xrx_ctl
    import xrx_pkg::*;
#(
    parameter int BAUD_W = 64
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [3:0]        data_bits_i,
    input  logic [BAUD_W-1:0] baud_i,
    input  logic              rxd_i,
    input  logic              eng_idle_i,
    input  logic              eng_sample_i,
`ifdef XRX_PARITY_EN
    input  logic              parity_odd_i,
`endif
    output logic [5:0]        eng_bits_o,
    output logic [BAUD_W-1:0] eng_baud_o,
    xrx_if.master             bus
);

    localparam logic [2:0] S_IDLE   = 3'(IDLE);
    localparam logic [2:0] S_START  = 3'(START);
    localparam logic [2:0] S_DATA   = 3'(DATA);
    localparam logic [2:0] S_STOP   = 3'(STOP);
    localparam logic [2:0] S_HUNT   = 3'(HUNT);
`ifdef XRX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'(PARITY);
    localparam logic       PAR_EN   = 1'b1;
`else
    localparam logic       PAR_EN   = 1'b0;
`endif

    logic [2:0]          state_r, state_nx_s;
    logic [3:0]          n_r;
    logic [5:0]          bits_r;
    logic [BAUD_W-1:0]   baud_r;
    logic                idle_d_r;
    logic [2:0]          k_r;
    logic [DATA_MAX-1:0] sr_r;
    logic                frame_err_r;
    logic                sample_s, cfg_load_s, last_s, done_s, ferr_s, stop_smp_s;
    logic [DATA_MAX-1:0] byte_s;

    assign sample_s   = eng_sample_i & ~eng_idle_i;
    assign cfg_load_s = (state_r == S_IDLE) & eng_idle_i;
    assign last_s     = ({1'b0, k_r} == (n_r - 4'd1));
    assign stop_smp_s = (state_r == S_STOP) & sample_s;
    // Data enters at the MSB, so a short frame sits in the top n bits.
    assign byte_s     = sr_r >> (4'(DATA_MAX) - n_r);
    assign eng_bits_o = bits_r;
    assign eng_baud_o = baud_r;

    // Frame configuration: tracks the inputs only while both FSM and engine are idle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            n_r    <= 4'd8;
            bits_r <= 6'd10;
            baud_r <= {BAUD_W{1'b0}};
        end else if (cfg_load_s) begin
            n_r    <= clamp_bits(data_bits_i);
            bits_r <= frame_bits(clamp_bits(data_bits_i), PAR_EN);
            baud_r <= baud_i;
        end else begin
            n_r    <= n_r;
            bits_r <= bits_r;
            baud_r <= baud_r;
        end
    end

    // Next-state logic and frame outcome strobes.
    always_comb begin
        state_nx_s = state_r;
        done_s     = 1'b0;
        ferr_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (idle_d_r && !eng_idle_i) begin
                    state_nx_s = S_START;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_START: begin
                if (eng_idle_i) begin
                    ferr_s     = 1'b1;
                    state_nx_s = S_IDLE;
                end else if (sample_s) begin
                    state_nx_s = rxd_i ? S_HUNT : S_DATA;
                end else begin
                    state_nx_s = S_START;
                end
            end
            S_DATA: begin
                if (eng_idle_i) begin
                    ferr_s     = 1'b1;
                    state_nx_s = S_IDLE;
                end else if (sample_s && last_s) begin
`ifdef XRX_PARITY_EN
                    state_nx_s = S_PARITY;
`else
                    state_nx_s = S_STOP;
`endif
                end else begin
                    state_nx_s = S_DATA;
                end
            end
`ifdef XRX_PARITY_EN
            S_PARITY: begin
                if (eng_idle_i) begin
                    ferr_s     = 1'b1;
                    state_nx_s = S_IDLE;
                end else if (sample_s) begin
                    state_nx_s = S_STOP;
                end else begin
                    state_nx_s = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                if (sample_s) begin
                    state_nx_s = S_IDLE;
                    done_s     = rxd_i;
                    ferr_s     = ~rxd_i;
                end else if (eng_idle_i) begin
                    // Engine gave up without sampling stop: nothing to report, just resync.
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_STOP;
                end
            end
            S_HUNT: begin
                if (eng_idle_i) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_HUNT;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // FSM state, idle edge history, bit counter, shift register and frame-error pulse.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r     <= S_IDLE;
            idle_d_r    <= 1'b1;
            k_r         <= 3'd0;
            sr_r        <= {DATA_MAX{1'b0}};
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            idle_d_r    <= eng_idle_i;
            frame_err_r <= ferr_s;
            if ((state_r == S_START) && sample_s && !rxd_i) begin
                k_r  <= 3'd0;
                sr_r <= {DATA_MAX{1'b0}};
            end else if ((state_r == S_DATA) && sample_s) begin
                k_r  <= k_r + 3'd1;
                sr_r <= {rxd_i, sr_r[DATA_MAX-1:1]};
            end else begin
                k_r  <= k_r;
                sr_r <= sr_r;
            end
        end
    end

`ifdef XRX_PARITY_EN
    logic par_odd_r, par_bad_r, parity_err_r;

    // Parity sense latched with the config; mismatch is reported at the stop sample.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            par_odd_r    <= 1'b0;
            par_bad_r    <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            if (cfg_load_s) begin
                par_odd_r <= parity_odd_i;
            end else begin
                par_odd_r <= par_odd_r;
            end
            if (state_r == S_START) begin
                par_bad_r <= 1'b0;
            end else if ((state_r == S_PARITY) && sample_s) begin
                par_bad_r <= rxd_i ^ even_parity(sr_r) ^ par_odd_r;
            end else begin
                par_bad_r <= par_bad_r;
            end
            parity_err_r <= stop_smp_s & par_bad_r;
        end
    end

    assign bus.parity_err_o = parity_err_r;
`endif

    assign bus.frame_err_o = frame_err_r;

    xrx_hold u_hold (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .load_i    (done_s),
        .byte_i    (byte_s),
        .ack_i     (bus.ack_i),
        .dat_o     (bus.dat_o),
        .stb_o     (bus.stb_o),
        .overrun_o (bus.overrun_o)
    );

endmodule
